// File: rtl/if_pc_pipe.sv
`default_nettype none
// ============================================================================
// Module   : if_pc_pipe
// Brief    : Fetch-stage PC register and IF/ID pipeline register with fetch count
// Revision : 1.0
// ============================================================================
module if_pc_pipe #(
  parameter logic [31:0] RESET_PC = 32'h0040_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic [31:0] pc_plus4,
  input  logic [31:0] inst_in,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        stall_if,
  input  logic        stall_id,
  input  logic        flush_id,
  output logic [31:0] pc,
  output logic [31:0] if_id_pc,
  output logic [31:0] if_id_pc4,
  output logic [31:0] if_id_inst,
  output logic        if_id_valid,
  output logic [31:0] fetch_cnt
);

  logic [31:0] r_pc;
  logic [31:0] r_if_id_pc;
  logic [31:0] r_if_id_pc4;
  logic [31:0] r_if_id_inst;
  logic        r_if_id_valid;
  logic [31:0] r_fetch_cnt;

  logic        w_bubble;
  logic        w_load;

  // A redirect squashes the younger instruction currently being fetched.
  assign w_bubble = redirect | flush_id;
  assign w_load   = ~w_bubble & ~stall_id;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_pc <= RESET_PC;
    end else if (redirect) begin
      r_pc <= {redirect_pc[31:2], 2'b00};
    end else if (!stall_if) begin
      r_pc <= pc_plus4;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_if_id_pc    <= 32'h0;
      r_if_id_pc4   <= 32'h0;
      r_if_id_inst  <= NOP_INST;
      r_if_id_valid <= 1'b0;
      r_fetch_cnt   <= 32'h0;
    end else if (w_bubble) begin
      r_if_id_pc    <= 32'h0;
      r_if_id_pc4   <= 32'h0;
      r_if_id_inst  <= NOP_INST;
      r_if_id_valid <= 1'b0;
    end else if (w_load) begin
      r_if_id_pc    <= r_pc;
      r_if_id_pc4   <= pc_plus4;
      r_if_id_inst  <= inst_in;
      r_if_id_valid <= 1'b1;
      r_fetch_cnt   <= r_fetch_cnt + 32'd1;
    end
  end

  assign pc          = r_pc;
  assign if_id_pc    = r_if_id_pc;
  assign if_id_pc4   = r_if_id_pc4;
  assign if_id_inst  = r_if_id_inst;
  assign if_id_valid = r_if_id_valid;
  assign fetch_cnt   = r_fetch_cnt;

endmodule
`default_nettype wire

// File: tb/tb_if_pc_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_if_pc_pipe
// Brief    : Directed self-checking bench for if_pc_pipe
// Revision : 1.0
// ============================================================================
module tb_if_pc_pipe;

  logic        clk;
  logic        rstn;
  logic [31:0] pc_plus4;
  logic [31:0] inst_in;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        stall_if;
  logic        stall_id;
  logic        flush_id;
  logic [31:0] pc;
  logic [31:0] if_id_pc;
  logic [31:0] if_id_pc4;
  logic [31:0] if_id_inst;
  logic        if_id_valid;
  logic [31:0] fetch_cnt;

  int n_pass;
  int n_total;

  localparam logic [31:0] C_NOP = 32'h0000_0013;

  function automatic logic [31:0] inst_of(input logic [31:0] a);
    return {a[15:0], ~a[15:0]};
  endfunction

  // Adder and imem stand-ins, combinational from pc.
  assign pc_plus4 = pc + 32'd4;
  assign inst_in  = inst_of(pc);

  if_pc_pipe dut (
    .clk         (clk),
    .rstn        (rstn),
    .pc_plus4    (pc_plus4),
    .inst_in     (inst_in),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .stall_if    (stall_if),
    .stall_id    (stall_id),
    .flush_id    (flush_id),
    .pc          (pc),
    .if_id_pc    (if_id_pc),
    .if_id_pc4   (if_id_pc4),
    .if_id_inst  (if_id_inst),
    .if_id_valid (if_id_valid),
    .fetch_cnt   (fetch_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed=%08h expected=%08h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all(input string tag, input logic [31:0] e_pc, input logic [31:0] e_ipc,
                         input logic [31:0] e_ipc4, input logic [31:0] e_inst,
                         input logic e_v, input logic [31:0] e_cnt);
    chk({tag, ".pc"},    pc,                  e_pc);
    chk({tag, ".ipc"},   if_id_pc,            e_ipc);
    chk({tag, ".ipc4"},  if_id_pc4,           e_ipc4);
    chk({tag, ".inst"},  if_id_inst,          e_inst);
    chk({tag, ".valid"}, {31'h0, if_id_valid}, {31'h0, e_v});
    chk({tag, ".cnt"},   fetch_cnt,           e_cnt);
  endtask

  initial begin
    n_pass      = 0;
    n_total     = 0;
    rstn        = 1'b0;
    redirect    = 1'b0;
    redirect_pc = 32'h0;
    stall_if    = 1'b0;
    stall_id    = 1'b0;
    flush_id    = 1'b0;

    #12;
    chk_all("reset", 32'h0040_0000, 32'h0, 32'h0, C_NOP, 1'b0, 32'd0);
    rstn = 1'b1;

    step();
    chk_all("run1", 32'h0040_0004, 32'h0040_0000, 32'h0040_0004,
            inst_of(32'h0040_0000), 1'b1, 32'd1);
    step();
    step();
    chk_all("run3", 32'h0040_000C, 32'h0040_0008, 32'h0040_000C,
            inst_of(32'h0040_0008), 1'b1, 32'd3);

    stall_if = 1'b1;
    stall_id = 1'b1;
    step();
    step();
    chk_all("stall", 32'h0040_000C, 32'h0040_0008, 32'h0040_000C,
            inst_of(32'h0040_0008), 1'b1, 32'd3);
    stall_if = 1'b0;
    stall_id = 1'b0;
    step();
    chk_all("resume", 32'h0040_0010, 32'h0040_000C, 32'h0040_0010,
            inst_of(32'h0040_000C), 1'b1, 32'd4);

    flush_id = 1'b1;
    step();
    flush_id = 1'b0;
    chk_all("flush", 32'h0040_0014, 32'h0, 32'h0, C_NOP, 1'b0, 32'd4);

    // Redirect must win over a simultaneous full stall; low bits dropped.
    redirect    = 1'b1;
    redirect_pc = 32'h0040_0103;
    stall_if    = 1'b1;
    stall_id    = 1'b1;
    step();
    redirect = 1'b0;
    stall_if = 1'b0;
    stall_id = 1'b0;
    chk_all("redir", 32'h0040_0100, 32'h0, 32'h0, C_NOP, 1'b0, 32'd4);
    step();
    chk_all("redir_tgt", 32'h0040_0104, 32'h0040_0100, 32'h0040_0104,
            inst_of(32'h0040_0100), 1'b1, 32'd5);

    redirect    = 1'b1;
    redirect_pc = 32'hFFFF_FFFC;
    step();
    redirect = 1'b0;
    chk("top.pc", pc, 32'hFFFF_FFFC);
    step();
    chk_all("wrap", 32'h0000_0000, 32'hFFFF_FFFC, 32'h0000_0000,
            inst_of(32'hFFFF_FFFC), 1'b1, 32'd6);

    step();
    #2;
    rstn = 1'b0;
    #1;
    chk_all("async_rst", 32'h0040_0000, 32'h0, 32'h0, C_NOP, 1'b0, 32'd0);
    rstn = 1'b1;
    step();
    chk_all("post_rst", 32'h0040_0004, 32'h0040_0000, 32'h0040_0004,
            inst_of(32'h0040_0000), 1'b1, 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
